// File: rtl/muldiv_ctrl_if.sv
// Divider handshake bundle between the EX-stage HI/LO controller (master) and the iterative divider (slave).
// Start/cancel/operands flow to the divider; quotient/remainder/status flow back.
interface muldiv_ctrl_if;
    logic        div_en;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_cancel;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_working;
    logic        div_finish;

    modport master (
        output div_en, div_sign, div_a, div_b, div_cancel,
        input  div_q, div_r, div_working, div_finish
    );

    modport slave (
        input  div_en, div_sign, div_a, div_b, div_cancel,
        output div_q, div_r, div_working, div_finish
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO owner: 2-cycle internal multiply, iterative divide via div handshake, MTHI/MTLO.
// Latency: MUL 2 stall cycles, DIV until div_finish; stall_req holds IF..EX while an op is in flight.
// MUL_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU (op 7-10); otherwise those codes are no-ops.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    muldiv_ctrl_if.master div
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_DIV_WAIT, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic        is_mul, is_div, mul_sx;
    logic        issue_mul, wr_hi_mt, wr_lo_mt, wr_prod, wr_div;
    logic        div_en_c, div_cancel_c;
    logic [31:0] op_a, op_b;
    logic        mul_sx_q;
    logic [63:0] mul_a_x, mul_b_x, prod_c, prod_q, hilo_acc;

`ifdef MUL_ACCUM_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;
    logic [1:0] acc_mode, acc_mode_q;
`endif

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        mul_sx = 1'b0;
`ifdef MUL_ACCUM_EN
        acc_mode = ACC_NONE;
`endif
        case (op)
            OP_MULT:  begin is_mul = 1'b1; mul_sx = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV,
            OP_DIVU:  is_div = 1'b1;
`ifdef MUL_ACCUM_EN
            OP_MADD:  begin is_mul = 1'b1; mul_sx = 1'b1; acc_mode = ACC_ADD; end
            OP_MADDU: begin is_mul = 1'b1; acc_mode = ACC_ADD; end
            OP_MSUB:  begin is_mul = 1'b1; mul_sx = 1'b1; acc_mode = ACC_SUB; end
            OP_MSUBU: begin is_mul = 1'b1; acc_mode = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    // Low 64 bits of a 64x64 product of extended operands equal the exact 32x32 result.
    assign mul_a_x = {{32{mul_sx_q & op_a[31]}}, op_a};
    assign mul_b_x = {{32{mul_sx_q & op_b[31]}}, op_b};
    assign prod_c  = mul_a_x * mul_b_x;

`ifdef MUL_ACCUM_EN
    always_comb begin
        case (acc_mode_q)
            ACC_ADD: hilo_acc = {hi, lo} + prod_q;
            ACC_SUB: hilo_acc = {hi, lo} - prod_q;
            default: hilo_acc = prod_q;
        endcase
    end
`else
    assign hilo_acc = prod_q;
`endif

    always_comb begin
        state_nxt    = state;
        stall_req    = 1'b0;
        div_en_c     = 1'b0;
        div_cancel_c = 1'b0;
        issue_mul    = 1'b0;
        wr_hi_mt     = 1'b0;
        wr_lo_mt     = 1'b0;
        wr_prod      = 1'b0;
        wr_div       = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    if (is_mul) begin
                        issue_mul = 1'b1;
                        stall_req = 1'b1;
                        state_nxt = S_MUL1;
                    end else if (is_div) begin
                        div_en_c  = 1'b1;
                        stall_req = 1'b1;
                        state_nxt = S_DIV_WAIT;
                    end else if (op == OP_MTHI) begin
                        wr_hi_mt = 1'b1;
                    end else if (op == OP_MTLO) begin
                        wr_lo_mt = 1'b1;
                    end
                end
            end
            S_MUL1: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    stall_req = 1'b1;
                    state_nxt = S_MUL2;
                end
            end
            S_MUL2: begin
                // op_valid here is the same instruction still sitting in EX.
                wr_prod   = !flush;
                state_nxt = S_IDLE;
            end
            S_DIV_WAIT: begin
                if (flush) begin
                    div_cancel_c = !div.div_finish;
                    state_nxt    = div.div_finish ? S_IDLE : S_DRAIN;
                end else if (div.div_finish) begin
                    wr_div    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall_req = 1'b1;
                end
            end
            S_DRAIN: begin
                stall_req = op_valid && !flush;
                if (div.div_finish) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            hi       <= 32'd0;
            lo       <= 32'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            mul_sx_q <= 1'b0;
            prod_q   <= 64'd0;
`ifdef MUL_ACCUM_EN
            acc_mode_q <= ACC_NONE;
`endif
        end else begin
            state <= state_nxt;
            if (issue_mul) begin
                op_a     <= src_a;
                op_b     <= src_b;
                mul_sx_q <= mul_sx;
`ifdef MUL_ACCUM_EN
                acc_mode_q <= acc_mode;
`endif
            end
            if (state == S_MUL1) prod_q <= prod_c;
            if (wr_prod) begin
                hi <= hilo_acc[63:32];
                lo <= hilo_acc[31:0];
            end else if (wr_div) begin
                hi <= div.div_r;
                lo <= div.div_q;
            end else begin
                if (wr_hi_mt) hi <= src_a;
                if (wr_lo_mt) lo <= src_a;
            end
        end
    end

    // A start while the divider still reports work would be a handshake protocol error.
    always_ff @(posedge clk) begin
        if (resetn) assert (!(div_en_c && div.div_working));
    end

    assign busy           = (state != S_IDLE);
    assign div.div_en     = div_en_c;
    assign div.div_cancel = div_cancel_c;
    assign div.div_sign   = (op == OP_DIV);
    assign div.div_a      = src_a;
    assign div.div_b      = src_b;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: scoreboard of expected {hi,lo} plus a 17-cycle iterative divider model.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall_req, busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    muldiv_ctrl_if div_if();

    muldiv_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stall_req(stall_req),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .div      (div_if)
    );

    always #5 clk = ~clk;

    // Divider model: finish in the 17th cycle after the start; cancel does not shorten it.
    logic [4:0]  dcnt;
    logic [31:0] mq, mr;
    always @(posedge clk) begin
        if (!resetn) begin
            dcnt <= 5'd0;
        end else if (div_if.div_en) begin
            dcnt <= 5'd17;
            if (div_if.div_b == 32'd0) begin
                mq <= 32'hFFFF_FFFF;
                mr <= div_if.div_a;
            end else if (div_if.div_sign) begin
                mq <= $signed(div_if.div_a) / $signed(div_if.div_b);
                mr <= $signed(div_if.div_a) % $signed(div_if.div_b);
            end else begin
                mq <= div_if.div_a / div_if.div_b;
                mr <= div_if.div_a % div_if.div_b;
            end
        end else if (dcnt != 5'd0) begin
            dcnt <= dcnt - 5'd1;
        end
    end
    assign div_if.div_q       = mq;
    assign div_if.div_r       = mr;
    assign div_if.div_working = (dcnt != 5'd0);
    assign div_if.div_finish  = (dcnt == 5'd1);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_chk(input string tag);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, {hi, lo});
        end else begin
            chk(tag, {hi, lo}, sb.pop_front());
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        op_valid = v;
        op       = o;
        src_a    = a;
        src_b    = b;
        flush    = f;
    endtask

    task automatic run_mul(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        @(posedge clk); #1 drive(1'b1, o, a, b, 1'b0);
        sb.push_back(exp);
        @(negedge clk); chk({tag, "_stall_issue"}, stall_req, 1);
        @(negedge clk); chk({tag, "_stall_mul1"}, stall_req, 1);
        @(negedge clk); chk({tag, "_stall_mul2"}, stall_req, 0);
        chk({tag, "_busy_mul2"}, busy, 1);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); chk({tag, "_busy_done"}, busy, 0);
        sb_chk({tag, "_hilo"});
    endtask

    task automatic mt(input string tag, input logic [3:0] o, input logic [31:0] v,
                      input logic f, input logic [63:0] exp);
        @(posedge clk); #1 drive(1'b1, o, v, 32'd0, f);
        sb.push_back(exp);
        @(negedge clk); chk({tag, "_stall"}, stall_req, 0);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); sb_chk({tag, "_hilo"});
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n_en, n_stall, n_cancel;
        bit  done;
        logic sign_seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_div_en", div_if.div_en, 0);
        chk("rst_cancel", div_if.div_cancel, 0);
        @(posedge clk); #1 resetn = 1'b1;

        run_mul("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        run_mul("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);

        // Multiply flushed in MUL1 leaves HI/LO alone.
        @(posedge clk); #1 drive(1'b1, 4'd2, 32'd5, 32'd5, 1'b0);
        sb.push_back(64'h0000_0002_FFFF_FFFA);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk); chk("mulflush_stall", stall_req, 0);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); chk("mulflush_busy", busy, 0);
        sb_chk("mulflush_hilo");

        // Signed divide -7 / 2.
        @(posedge clk); #1 drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        n_en = 0; n_stall = 0; done = 0; sign_seen = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (div_if.div_en) begin
                n_en++;
                sign_seen = div_if.div_sign;
            end
            if (stall_req) n_stall++;
            else done = 1;
        end
        chk("div_finish_seen", done, 1);
        chk("div_en_pulses", n_en, 1);
        chk("div_sign", sign_seen, 1);
        chk("div_stall_cycles", n_stall, 17);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); chk("div_busy_done", busy, 0);
        sb_chk("div_hilo");

        // Unsigned divide flushed mid-flight, MTLO offered while draining.
        @(posedge clk); #1 drive(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk); chk("divu_en", div_if.div_en, 1);
        chk("divu_sign", div_if.div_sign, 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk); chk("divu_cancel", div_if.div_cancel, 1);
        chk("divu_flush_stall", stall_req, 0);
        @(posedge clk); #1 drive(1'b1, 4'd6, 32'h1234_5678, 32'd0, 1'b0);
        sb.push_back(64'hFFFF_FFFF_1234_5678);
        @(negedge clk); chk("drain_cancel_off", div_if.div_cancel, 0);
        chk("drain_busy", busy, 1);
        chk("drain_stall", stall_req, 1);
        n_cancel = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (div_if.div_cancel) n_cancel++;
            if (!busy) done = 1;
        end
        chk("drain_exit_seen", done, 1);
        chk("drain_extra_cancel", n_cancel, 0);
        chk("idle_mt_stall", stall_req, 0);
        sb_chk("divu_flush_hilo");
        @(posedge clk); #1 drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk); sb_chk("drain_mtlo_hilo");

        mt("mthi", 4'd5, 32'hCAFE_F00D, 1'b0, 64'hCAFE_F00D_1234_5678);
        mt("mtlo_flush", 4'd6, 32'hDEAD_0000, 1'b1, 64'hCAFE_F00D_1234_5678);

`ifdef MUL_ACCUM_EN
        mt("mthi0", 4'd5, 32'd0, 1'b0, 64'h0000_0000_1234_5678);
        mt("mtlo1s", 4'd6, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF);
        run_mul("maddu", 4'd8, 32'd1, 32'd1, 64'h0000_0001_0000_0000);
        run_mul("msub",  4'd9, 32'd1, 32'd2, 64'h0000_0000_FFFF_FFFE);
`else
        mt("op7_noop", 4'd7, 32'd9, 1'b0, 64'hCAFE_F00D_1234_5678);
`endif

        // Reset while a divide is in flight.
        @(posedge clk); #1 drive(1'b1, 4'd3, 32'd9, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1 begin
            resetn = 1'b0;
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst2_busy", busy, 0);
        chk("rst2_hilo", {hi, lo}, 64'd0);
        chk("rst2_stall", stall_req, 0);
        chk("rst2_div_en", div_if.div_en, 0);
        chk("rst2_cancel", div_if.div_cancel, 0);
        @(posedge clk); #1 resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- EX-stage HI/LO unit and initiator side of the iterative divider handshake (en/sign/A/B/cancel out; Q/R/working/finish in).
- Decodes multiply/divide/move-to-HI/LO ops, holds the pipeline via stall_req while an op is in flight, and owns the architectural HI/LO registers.
- Handles exception flush, including cancelling and draining an in-flight divide.
- Multiply is internal: two-cycle, product registered.

Parameters:
- none

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
op_valid  in  1  EX holds a muldiv-class op; held stable while stall_req=1
op  in  4  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-10 see Optional Feature, other codes no-op
src_a  in  32  rs value
src_b  in  32  rt value
flush  in  1  exception/ERET flush of EX this cycle
stall_req  out  1  hold IF..EX this cycle (combinational)
busy  out  1  FSM not IDLE
hi  out  32  HI register
lo  out  32  LO register
div_en  out  1  one-cycle divide start (combinational)
div_sign  out  1  1 for DIV
div_a  out  32  dividend (= src_a)
div_b  out  32  divisor (= src_b)
div_cancel  out  1  one-cycle abort pulse
div_q  in  32  quotient
div_r  in  32  remainder
div_working  in  1  divider busy (monitor only)
div_finish  in  1  result valid this cycle

Behaviour:
- Reset: state=IDLE; hi=0, lo=0; stall_req=0, busy=0, div_en=0, div_cancel=0.
- States: IDLE, MUL1, MUL2, DIV_WAIT, DRAIN. flush has highest priority in every state.
- IDLE:
  - op_valid && !flush, MULT/MULTU: capture operands; stall_req=1; go MUL1.
  - DIV/DIVU: div_en=1 this cycle, div_sign=(op==DIV); stall_req=1; go DIV_WAIT.
  - MTHI/MTLO: write hi/lo from src_a at the clock edge; no stall; stay IDLE.
  - flush=1: no issue, no write, stall_req=0.
- MUL1:
  - Register the 64-bit product: signed (33-bit sign-extended) for MULT, zero-extended for MULTU.
  - stall_req=1; go MUL2.
- MUL2:
  - stall_req=0; {hi,lo} <= product at the edge; go IDLE.
  - op_valid is ignored this cycle: the same instruction is still in EX.
- DIV_WAIT:
  - stall_req=1 until div_finish.
  - Cycle with div_finish=1: stall_req=0; hi<=div_r, lo<=div_q; go IDLE; op_valid ignored.
  - Divide by zero: results written as returned; no trap.
- Flush:
  - In MUL1/MUL2: go IDLE, no write.
  - In DIV_WAIT without div_finish: div_cancel=1 for exactly that cycle; go DRAIN.
  - In DIV_WAIT with div_finish in the same cycle: discard result, no cancel, go IDLE.
- DRAIN:
  - busy=1; wait for div_finish, discard the result, go IDLE.
  - A new op_valid here gets stall_req=1 and is not issued (including MT*) until IDLE.
- div_en is never asserted outside IDLE, and at most once per instruction.
- busy = (state != IDLE).

Optional Feature:
- Macro MUL_ACCUM_EN.
- Defined: op 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU use the MUL1/MUL2 path with the signedness of MULT/MULTU. MUL2 writes {hi,lo} <= {hi,lo} ± product, mod 2^64. Flush behaviour is the same as MULT.
- Undefined: codes 7-10 are no-ops (no stall, no write).

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 -> stall_req high 2 cycles (issue, MUL1), low in MUL2; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA; no second issue while op_valid is held through MUL2.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2, divider model with 17-cycle finish -> single div_en pulse, div_sign=1; stall until finish; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 with flush 5 cycles after issue -> div_cancel pulse of 1 cycle; hi/lo unchanged; busy until div_finish. MTLO 0x12345678 offered in DRAIN stalls, then writes lo the cycle after IDLE.
- MTHI 0xCAFEF00D -> hi updated at the next edge, stall_req=0. MTLO with flush=1 -> lo unchanged. Reset asserted in DIV_WAIT -> state IDLE, hi=lo=0, all outputs 0.
- MUL_ACCUM_EN defined, hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Then MSUB 1*2 -> hi=0, lo=0xFFFFFFFE.
